// File: rtl/tri_job_arbiter_pkg.sv
// Shared definitions for the triangle job arbiter: FSM state encoding and the
// layout of one packed triangle word {x1,y1,x2,y2,x3,y3}.
package tri_job_arbiter_pkg;

  localparam int unsigned DEF_COORD_W = 3;
  localparam int unsigned VTX_FIELDS  = 6;

  // Field index within the triangle word; multiply by COORD_W for the LSB.
  localparam int unsigned X1_F = 5;
  localparam int unsigned Y1_F = 4;
  localparam int unsigned X2_F = 3;
  localparam int unsigned Y2_F = 2;
  localparam int unsigned X3_F = 1;
  localparam int unsigned Y3_F = 0;

  typedef enum logic [6:0] {
    ST_IDLE      = 7'b0000001,
    ST_SEND1     = 7'b0000010,
    ST_SEND2     = 7'b0000100,
    ST_SEND3     = 7'b0001000,
    ST_WAIT_BUSY = 7'b0010000,
    ST_WAIT_DONE = 7'b0100000,
    ST_DONE      = 7'b1000000
  } state_e;

endpackage

// File: rtl/tri_job_arbiter_rr_arbiter.sv
// Round-robin requester select: first requesting index after last_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] last_i,
  output logic [N_REQ-1:0] sel_o,
  output logic             valid_o
);

  // Two passes: indices above the pointer first, then wrap to the low ones.
  always_comb begin
    sel_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!valid_o && req_i[i] && (i > 32'(last_i))) begin
        sel_o[i] = 1'b1;
        valid_o  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!valid_o && req_i[i] && (i <= 32'(last_i))) begin
        sel_o[i] = 1'b1;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_job_arbiter.sv
// Shares one triangle engine between N_REQ sources: round-robin pick, latch the
// triangle, stream three vertices, wait out the engine's busy, report done.
module tri_job_arbiter
  import tri_job_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned COORD_W      = DEF_COORD_W,
  parameter int unsigned BUSY_TIMEOUT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*VTX_FIELDS*COORD_W-1:0] vtx,
  output logic [N_REQ-1:0]                gnt,
  output logic [N_REQ-1:0]                done,
  input  logic                            busy,
  output logic                            nt,
  output logic [COORD_W-1:0]              xo,
  output logic [COORD_W-1:0]              yo,
  output logic [CNT_W-1:0]                tri_count
);

  localparam int unsigned TRI_W = VTX_FIELDS * COORD_W;
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TO_W  = $clog2(BUSY_TIMEOUT + 1);

  state_e             state_q;
  logic [TRI_W-1:0]   tri_q;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   last_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic               nt_q;
  logic [COORD_W-1:0] xo_q;
  logic [COORD_W-1:0] yo_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [N_REQ-1:0]   arb_sel;
  logic               arb_valid;
  logic [TRI_W-1:0]   tri_d;
  logic [PTR_W-1:0]   owner_d;
  logic [N_REQ-1:0]   owner_oh;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i   (req),
    .last_i  (last_q),
    .sel_o   (arb_sel),
    .valid_o (arb_valid)
  );

  // Decode the arbiter's one-hot pick into an index and its triangle word.
  always_comb begin
    tri_d   = '0;
    owner_d = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_sel[i]) begin
        tri_d   = vtx[i*TRI_W +: TRI_W];
        owner_d = PTR_W'(i);
      end
    end
  end

  // One-hot form of the current job owner for the done pulse.
  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      owner_oh[i] = (owner_q == PTR_W'(i));
    end
  end

  // Job FSM; every output is registered on entry to the state that shows it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      tri_q    <= '0;
      owner_q  <= '0;
      last_q   <= PTR_W'(N_REQ - 1);
      to_cnt_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      nt_q     <= 1'b0;
      xo_q     <= '0;
      yo_q     <= '0;
      cnt_q    <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      nt_q   <= 1'b0;
      xo_q   <= '0;
      yo_q   <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (!busy && arb_valid) begin
            tri_q   <= tri_d;
            owner_q <= owner_d;
            gnt_q   <= arb_sel;
            nt_q    <= 1'b1;
            xo_q    <= tri_d[X1_F*COORD_W +: COORD_W];
            yo_q    <= tri_d[Y1_F*COORD_W +: COORD_W];
            state_q <= ST_SEND1;
          end
        end
        ST_SEND1: begin
          xo_q    <= tri_q[X2_F*COORD_W +: COORD_W];
          yo_q    <= tri_q[Y2_F*COORD_W +: COORD_W];
          state_q <= ST_SEND2;
        end
        ST_SEND2: begin
          xo_q    <= tri_q[X3_F*COORD_W +: COORD_W];
          yo_q    <= tri_q[Y3_F*COORD_W +: COORD_W];
          state_q <= ST_SEND3;
        end
        ST_SEND3: begin
          to_cnt_q <= '0;
          state_q  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
            done_q  <= owner_oh;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!busy) begin
            done_q  <= owner_oh;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_q  <= owner_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign nt        = nt_q;
  assign xo        = xo_q;
  assign yo        = yo_q;
  assign tri_count = cnt_q;

endmodule

// File: tb/tb_tri_job_arbiter.sv
// Scoreboard bench for tri_job_arbiter: stimulus pushes expected grants/dones
// with their cycle numbers, a negedge monitor pops and compares.
module tb_tri_job_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned CW = 3;
  localparam int unsigned TW = 6 * CW;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N*TW-1:0] vtx   = '0;
  logic            busy  = 1'b0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            nt;
  logic [CW-1:0]   xo;
  logic [CW-1:0]   yo;
  logic [7:0]      tri_count;

  tri_job_arbiter #(
    .N_REQ        (2),
    .COORD_W      (3),
    .BUSY_TIMEOUT (8),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .vtx       (vtx),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .nt        (nt),
    .xo        (xo),
    .yo        (yo),
    .tri_count (tri_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [N-1:0] vec;
    logic [TW-1:0] tri_w;
    logic [7:0]  cnt;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // {x1,y1,x2,y2,x3,y3}
  localparam logic [TW-1:0] T0 = {3'd1, 3'd1, 3'd4, 3'd1, 3'd1, 3'd7};
  localparam logic [TW-1:0] T1 = {3'd1, 3'd1, 3'd7, 3'd1, 3'd1, 3'd3};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic exp_t mk(int c, logic [N-1:0] v, logic [TW-1:0] t, logic [7:0] n);
    exp_t e;
    e.cyc = c; e.vec = v; e.tri_w = t; e.cnt = n;
    return e;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [TW-1:0] cur_tri;
  int vph = 0;

  // Monitor: compares every grant/done pulse against the scoreboard queues.
  always @(negedge clk) begin
    exp_t e;
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    chk("done_onehot0", 32'($onehot0(done)), 1);
    chk("nt_only_with_gnt", 32'(nt), 32'(gnt != '0));
    if (gnt != '0) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 32'(gnt), 0);
      end else begin
        e = gq.pop_front();
        chk("gnt_vec", 32'(gnt), 32'(e.vec));
        chk("gnt_cycle", cyc, e.cyc);
        chk("x1", 32'(xo), 32'(e.tri_w[17:15]));
        chk("y1", 32'(yo), 32'(e.tri_w[14:12]));
        cur_tri = e.tri_w;
        vph = 1;
      end
    end else if (vph == 1) begin
      chk("x2", 32'(xo), 32'(cur_tri[11:9]));
      chk("y2", 32'(yo), 32'(cur_tri[8:6]));
      vph = 2;
    end else if (vph == 2) begin
      chk("x3", 32'(xo), 32'(cur_tri[5:3]));
      chk("y3", 32'(yo), 32'(cur_tri[2:0]));
      vph = 0;
    end else begin
      chk("xo_quiet", 32'(xo), 0);
      chk("yo_quiet", 32'(yo), 0);
    end
    if (done != '0) begin
      if (dq.size() == 0) begin
        chk("done_unexpected", 32'(done), 0);
      end else begin
        e = dq.pop_front();
        chk("done_vec", 32'(done), 32'(e.vec));
        chk("done_cycle", cyc, e.cyc);
        chk("done_tri_count", 32'(tri_count), 32'(e.cnt));
      end
    end
  end

  // Directed stimulus; each test computes the cycle of every expected pulse.
  initial begin
    int a;
    step(3);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_nt", 32'(nt), 0);
    chk("rst_xo", 32'(xo), 0);
    chk("rst_yo", 32'(yo), 0);
    chk("rst_count", 32'(tri_count), 0);

    // Single job, busy high 10 cycles in WAIT_BUSY/WAIT_DONE.
    reset = 1'b1;
    vtx[0*TW +: TW] = T0;
    vtx[1*TW +: TW] = T1;
    req = 2'b01;
    a = cyc;
    gq.push_back(mk(a + 1, 2'b01, T0, 8'd0));
    dq.push_back(mk(a + 15, 2'b01, T0, 8'd1));
    step(1); req = 2'b00;
    step(3); busy = 1'b1;
    step(10); busy = 1'b0;
    step(2);

    // Contention with busy never rising: r0,r1,r0,r1 via timeout path.
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    req = 2'b11;
    a = cyc;
    gq.push_back(mk(a + 1, 2'b01, T0, 8'd0));
    gq.push_back(mk(a + 14, 2'b10, T1, 8'd0));
    gq.push_back(mk(a + 27, 2'b01, T0, 8'd0));
    gq.push_back(mk(a + 40, 2'b10, T1, 8'd0));
    dq.push_back(mk(a + 12, 2'b01, T0, 8'd1));
    dq.push_back(mk(a + 25, 2'b10, T1, 8'd2));
    dq.push_back(mk(a + 38, 2'b01, T0, 8'd3));
    dq.push_back(mk(a + 51, 2'b10, T1, 8'd4));
    step(40); req = 2'b00;
    step(12);

    // busy held in IDLE blocks the grant to requester 1.
    a = cyc;
    busy = 1'b1;
    req = 2'b10;
    step(5); busy = 1'b0;
    gq.push_back(mk(a + 6, 2'b10, T1, 8'd0));
    dq.push_back(mk(a + 17, 2'b10, T1, 8'd5));
    step(1); req = 2'b00;
    step(12);

    // Reset in WAIT_DONE discards the job; r0 then wins the tie, r1 drops out.
    a = cyc;
    req = 2'b01;
    gq.push_back(mk(a + 1, 2'b01, T0, 8'd0));
    step(1); req = 2'b00;
    step(3); busy = 1'b1;
    step(2); reset = 1'b0;
    step(1);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_nt", 32'(nt), 0);
    chk("mid_rst_xo", 32'(xo), 0);
    chk("mid_rst_yo", 32'(yo), 0);
    chk("mid_rst_count", 32'(tri_count), 0);
    busy = 1'b0;
    step(1);
    reset = 1'b1;
    req = 2'b11;
    gq.push_back(mk(a + 9, 2'b01, T0, 8'd0));
    dq.push_back(mk(a + 20, 2'b01, T0, 8'd1));
    step(1); req = 2'b00;
    step(12);

    // 256 back-to-back jobs from r0: tri_count wraps to 0 on the last done.
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    req = 2'b01;
    a = cyc;
    for (int j = 0; j < 256; j++) begin
      gq.push_back(mk(a + 1 + 13 * j, 2'b01, T0, 8'd0));
      dq.push_back(mk(a + 12 + 13 * j, 2'b01, T0, 8'((j + 1) % 256)));
    end
    step(1 + 13 * 255); req = 2'b00;
    step(14);
    chk("final_count", 32'(tri_count), 0);
    chk("gnt_queue_empty", gq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
